fft_out_reorder: RTL and testbench

FFT_OUT_REORDER -- requirements
Module: fft_out_reorder

---
 rtl/fft_out_reorder.sv | 191 +++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer that reorders bit-reversed FFT bins
// into natural order. Optional peak tracker enabled by FFT_REORDER_PEAK_EN.
module fft_out_reorder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] In_Stream,
  input  logic        In_Valid,
  output logic [31:0] Out_Stream,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [5:0]  Out_Index,
  output logic        Out_Last,
  output logic        Overflow
`ifdef FFT_REORDER_PEAK_EN
  ,
  output logic [5:0]  Peak_Bin,
  output logic [16:0] Peak_Mag,
  output logic        Peak_Valid
`endif
);

  localparam logic [1:0] B_FREE = 2'd0;
  localparam logic [1:0] B_FILL = 2'd1;
  localparam logic [1:0] B_FULL = 2'd2;

  localparam logic [0:0] R_IDLE   = 1'b0;
  localparam logic [0:0] R_STREAM = 1'b1;

  function automatic logic [5:0] bitrev6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

  logic [31:0]     mem [0:127];
  logic [1:0][1:0] bank_st;
  logic            wptr;
  logic            rptr;
  logic [5:0]      wcnt;
  logic [0:0]      rstate;
  logic            arm;

  logic            wr_full;
  logic            wr_acc;
  logic [6:0]      wr_addr;
  logic            rd_full;
  logic            oth_full;
  logic            xfer;
  logic            fin;
  logic [5:0]      nxt_idx;
  logic [6:0]      rd_addr;

  // Handshake and bank status decode.
  always_comb begin
    wr_full  = (bank_st[wptr] == B_FULL);
    wr_acc   = In_Valid && !wr_full && !rst;
    wr_addr  = {wptr, bitrev6(wcnt)};
    rd_full  = (bank_st[rptr] == B_FULL);
    oth_full = (bank_st[~rptr] == B_FULL);
    xfer     = Out_Valid && Out_Ready;
    fin      = xfer && Out_Last;
    nxt_idx  = Out_Index + 6'd1;
  end

  // Next read address: next bin, or bin 0 of the other bank at frame end.
  always_comb begin
    rd_addr = {rptr, 6'd0};
    if (fin)
      rd_addr = {~rptr, 6'd0};
    else if (xfer)
      rd_addr = {rptr, nxt_idx};
  end

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_addr] <= In_Stream;
  end

  // Bank bookkeeping, write counter and read FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st    <= {B_FREE, B_FREE};
      wptr       <= 1'b0;
      rptr       <= 1'b0;
      wcnt       <= 6'd0;
      rstate     <= R_IDLE;
      arm        <= 1'b0;
      Out_Stream <= 32'd0;
      Out_Valid  <= 1'b0;
      Out_Index  <= 6'd0;
      Out_Last   <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wcnt <= wcnt + 6'd1;
        if (wcnt == 6'd63) begin
          bank_st[wptr] <= B_FULL;
          wptr          <= ~wptr;
        end else begin
          bank_st[wptr] <= B_FILL;
        end
      end else if (In_Valid) begin
        Overflow <= 1'b1;
      end

      unique case (rstate)
        R_IDLE: begin
          arm <= rd_full;
          if (arm && rd_full) begin
            rstate     <= R_STREAM;
            arm        <= 1'b0;
            Out_Stream <= mem[rd_addr];
            Out_Valid  <= 1'b1;
            Out_Index  <= 6'd0;
            Out_Last   <= 1'b0;
          end
        end
        R_STREAM: begin
          if (fin) begin
            bank_st[rptr] <= B_FREE;
            rptr          <= ~rptr;
            Out_Index     <= 6'd0;
            Out_Last      <= 1'b0;
            if (oth_full) begin
              Out_Stream <= mem[rd_addr];
            end else begin
              rstate    <= R_IDLE;
              Out_Valid <= 1'b0;
            end
          end else if (xfer) begin
            Out_Stream <= mem[rd_addr];
            Out_Index  <= nxt_idx;
            Out_Last   <= (nxt_idx == 6'd63);
          end
        end
      endcase
    end
  end

`ifdef FFT_REORDER_PEAK_EN
  logic [15:0] re_v;
  logic [15:0] im_v;
  logic [15:0] re_abs;
  logic [15:0] im_abs;
  logic [16:0] mag;
  logic [5:0]  nbin;
  logic        take;
  logic [5:0]  sel_bin;
  logic [16:0] sel_mag;
  logic [5:0]  cur_bin;
  logic [16:0] cur_mag;

  // Magnitude of the incoming sample and running-peak selection.
  always_comb begin
    re_v    = In_Stream[31:16];
    im_v    = In_Stream[15:0];
    re_abs  = re_v[15] ? (~re_v + 16'd1) : re_v;
    im_abs  = im_v[15] ? (~im_v + 16'd1) : im_v;
    mag     = {1'b0, re_abs} + {1'b0, im_abs};
    nbin    = bitrev6(wcnt);
    take    = (wcnt == 6'd0) || (mag > cur_mag) ||
              ((mag == cur_mag) && (nbin < cur_bin));
    sel_bin = take ? nbin : cur_bin;
    sel_mag = take ? mag : cur_mag;
  end

  // Per-frame peak tracking, published when the frame completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_bin    <= 6'd0;
      cur_mag    <= 17'd0;
      Peak_Bin   <= 6'd0;
      Peak_Mag   <= 17'd0;
      Peak_Valid <= 1'b0;
    end else begin
      Peak_Valid <= 1'b0;
      if (wr_acc) begin
        cur_bin <= sel_bin;
        cur_mag <= sel_mag;
        if (wcnt == 6'd63) begin
          Peak_Bin   <= sel_bin;
          Peak_Mag   <= sel_mag;
          Peak_Valid <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed table-driven bench for fft_out_reorder.
// Peak checks are active when FFT_REORDER_PEAK_EN is defined.
module tb_fft_out_reorder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] In_Stream;
  logic        In_Valid;
  logic [31:0] Out_Stream;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [5:0]  Out_Index;
  logic        Out_Last;
  logic        Overflow;
`ifdef FFT_REORDER_PEAK_EN
  logic [5:0]  Peak_Bin;
  logic [16:0] Peak_Mag;
  logic        Peak_Valid;
`endif

  always #5 clk = ~clk;

  fft_out_reorder dut (
    .clk        (clk),
    .rst        (rst),
    .In_Stream  (In_Stream),
    .In_Valid   (In_Valid),
    .Out_Stream (Out_Stream),
    .Out_Valid  (Out_Valid),
    .Out_Ready  (Out_Ready),
    .Out_Index  (Out_Index),
    .Out_Last   (Out_Last),
    .Overflow   (Overflow)
`ifdef FFT_REORDER_PEAK_EN
    ,
    .Peak_Bin   (Peak_Bin),
    .Peak_Mag   (Peak_Mag),
    .Peak_Valid (Peak_Valid)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    string       name;
    int          mode;
    logic [31:0] cval;
    bit          tog;
    int          spot;
    logic [31:0] spot_val;
    logic [5:0]  pk_bin;
    logic [16:0] pk_mag;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    n_total++;
    if (act === expv)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  function automatic logic [5:0] bitrev(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

  function automatic logic [31:0] gen(input int mode,
                                      input logic [31:0] cval,
                                      input int i);
    logic [5:0] ii;
    logic [5:0] b;
    ii = 6'(i);
    b  = bitrev(ii);
    case (mode)
      0: return {26'd0, b};
      1: return cval;
      2: return (b == 6'd5 || b == 6'd9) ? 32'h01000000 : 32'h0;
      default: return cval ^ {26'd0, ii};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int mode, input logic [31:0] cval,
                      input int n, input bit kept);
    logic [5:0] kk;
    for (int i = 0; i < n; i++) begin
      In_Valid  = 1'b1;
      In_Stream = gen(mode, cval, i);
      step();
    end
    In_Valid  = 1'b0;
    In_Stream = 32'd0;
    if (kept) begin
      for (int k = 0; k < 64; k++) begin
        kk = 6'(k);
        exp_q.push_back(gen(mode, cval, int'(bitrev(kk))));
      end
    end
  endtask

  task automatic drain(input int nw, input bit tog, input int spot,
                       output logic [31:0] sw);
    int          got;
    int          cyc;
    bit          ph;
    bit          stalled;
    logic [31:0] ps;
    logic [5:0]  pi;
    logic        pl;
    logic [31:0] ew;
    got     = 0;
    cyc     = 0;
    ph      = 1'b0;
    stalled = 1'b0;
    sw      = 32'hx;
    ps      = 32'd0;
    pi      = 6'd0;
    pl      = 1'b0;
    while (got < nw && cyc < 2000) begin
      Out_Ready = tog ? ph : 1'b1;
      ph        = ~ph;
      if (stalled)
        chk("hold", {Out_Valid, Out_Last, Out_Index, Out_Stream},
            {1'b1, pl, pi, ps});
      if (!tog && got > 0)
        chk("no_gap", Out_Valid, 1);
      stalled = 1'b0;
      if (Out_Valid) begin
        if (Out_Ready) begin
          ew = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
          chk("data", Out_Stream, ew);
          chk("index", Out_Index, 64'(got % 64));
          chk("last", Out_Last, 64'(got % 64 == 63));
          if (got % 64 == spot) sw = Out_Stream;
          got++;
        end else begin
          stalled = 1'b1;
          ps = Out_Stream;
          pi = Out_Index;
          pl = Out_Last;
        end
      end
      step();
      cyc++;
    end
    if (got < nw)
      chk("drain_timeout", 64'(got), 64'(nw));
    chk("idle_after", Out_Valid, 0);
  endtask

  task automatic latency_chk();
    chk("lat_e0", Out_Valid, 0);
    step();
    chk("lat_e1", Out_Valid, 0);
`ifdef FFT_REORDER_PEAK_EN
    chk("pk_pulse_end", Peak_Valid, 0);
`endif
    step();
    chk("lat_e2", Out_Valid, 1);
    chk("lat_idx0", Out_Index, 0);
  endtask

  initial begin
    logic [31:0] sw;
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
    sw = 0;
  end

  initial begin
    logic [31:0] sw;
    tbl[0] = '{"ramp", 0, 32'h0, 1'b0, 37, 32'h00000025, 6'd63, 17'h3F};
    tbl[1] = '{"const29", 1, 32'h00290000, 1'b0, 63, 32'h00290000,
               6'd0, 17'h29};
    tbl[2] = '{"twopk", 2, 32'h0, 1'b0, 9, 32'h01000000, 6'd5, 17'h100};
    tbl[3] = '{"ramp_tog", 0, 32'h0, 1'b1, 50, 32'h00000032,
               6'd63, 17'h3F};
    tbl[4] = '{"negmax", 1, 32'h8000FFFF, 1'b1, 20, 32'h8000FFFF,
               6'd0, 17'h8001};

    rst       = 1'b1;
    In_Valid  = 1'b0;
    In_Stream = 32'd0;
    Out_Ready = 1'b0;
    repeat (3) step();
    chk("rst_valid", Out_Valid, 0);
    chk("rst_last", Out_Last, 0);
    chk("rst_index", Out_Index, 0);
    chk("rst_stream", Out_Stream, 0);
    chk("rst_ovf", Overflow, 0);
`ifdef FFT_REORDER_PEAK_EN
    chk("rst_pk", {Peak_Valid, Peak_Bin, Peak_Mag}, 0);
`endif
    rst = 1'b0;
    step();

    for (int t = 0; t < 5; t++) begin
      feed(tbl[t].mode, tbl[t].cval, 64, 1'b1);
`ifdef FFT_REORDER_PEAK_EN
      chk("pk_valid", Peak_Valid, 1);
      chk("pk_bin", Peak_Bin, tbl[t].pk_bin);
      chk("pk_mag", Peak_Mag, tbl[t].pk_mag);
`endif
      latency_chk();
      drain(64, tbl[t].tog, tbl[t].spot, sw);
      chk("spot", sw, tbl[t].spot_val);
      chk("ovf_clear", Overflow, 0);
    end

    Out_Ready = 1'b0;
    feed(0, 32'h0, 64, 1'b1);
    feed(3, 32'hC3C30F00, 64, 1'b1);
    feed(1, 32'hDEADBEEF, 64, 1'b0);
    repeat (8) step();
    chk("ovf_set", Overflow, 1);
    chk("stall_valid", Out_Valid, 1);
    chk("stall_idx", Out_Index, 0);
    drain(128, 1'b0, 0, sw);
    chk("ovf_spot", sw, 32'hC3C30F00);
    chk("ovf_q_empty", 64'(exp_q.size()), 0);

    feed(0, 32'h0, 30, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_ovf", Overflow, 0);
    chk("mid_rst_valid", Out_Valid, 0);
    feed(3, 32'h5A5A0000, 64, 1'b1);
    latency_chk();
    drain(64, 1'b0, 1, sw);
    chk("mid_rst_spot", sw, 32'h5A5A0020);
    repeat (5) step();
    chk("mid_rst_quiet", Out_Valid, 0);
    chk("mid_rst_ovf2", Overflow, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
